// File: rtl/fifo_burst_reader.sv
// Drains a requested number of words from a FIFO into a valid/ready stream.
// A two-entry skid buffer absorbs the one-cycle FIFO read latency.
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  Read_enable,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_WIDTH-1:0]  word_count
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

   state_t state, state_nxt;

   logic [LEN_WIDTH-1:0]  len;
   logic [LEN_WIDTH-1:0]  issued;
   logic [1:0]            occ;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] tail;
   logic                  pop;
   logic [2:0]            level;
   logic                  last_issue;
   logic                  last_pop;

   assign m_valid = (occ != 2'd0);
   assign m_data  = head;
   assign pop     = m_valid && m_ready;

   // Buffer level once the in-flight word lands and the current pop leaves
   assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

   assign last_issue = Read_enable && (issued == len - LEN_ONE);
   assign last_pop   = pop && (occ == 2'd1) && !inflight;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start)
               state_nxt = (burst_len != '0) ? RUN : DONE;
         end
         RUN: begin
            if (last_issue) state_nxt = FLUSH;
         end
         FLUSH: begin
            if (last_pop) state_nxt = DONE;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      Read_enable = 1'b0;
      unique case (state)
         RUN: begin
            busy        = 1'b1;
            Read_enable = !empty && (issued < len) && (level < 3'd2);
         end
         FLUSH: busy = 1'b1;
         DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len        <= '0;
         issued     <= '0;
         word_count <= '0;
         inflight   <= 1'b0;
         occ        <= 2'd0;
         head       <= '0;
         tail       <= '0;
      end else begin
         if (state == IDLE && start) begin
            len        <= burst_len;
            issued     <= '0;
            word_count <= '0;
         end else begin
            if (Read_enable)
               issued <= issued + LEN_ONE;
            if (pop && word_count < len)
               word_count <= word_count + LEN_ONE;
         end
         inflight <= Read_enable;
         case ({inflight, pop})
            2'b11: begin
               if (occ == 2'd1) begin
                  head <= data_out;
               end else begin
                  head <= tail;
                  tail <= data_out;
               end
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            2'b10: begin
               if (occ == 2'd0) head <= data_out;
               else             tail <= data_out;
               occ <= occ + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a one-cycle-latency FIFO model.
// Each scenario task drives a burst and checks the logged stream.
module tb_fifo_burst_reader;

   localparam int DW = 32;
   localparam int LW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          empty;
   logic [DW-1:0] data_out;
   logic          Read_enable;
   logic          start;
   logic [LW-1:0] burst_len;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          busy;
   logic          done;
   logic [LW-1:0] word_count;

   fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk),
      .reset(reset),
      .empty(empty),
      .data_out(data_out),
      .Read_enable(Read_enable),
      .start(start),
      .burst_len(burst_len),
      .m_data(m_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .busy(busy),
      .done(done),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int cyc = 0;

   assign empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (Read_enable && !empty) begin
         data_out <= mem[rd_ptr];
         rd_ptr   <= rd_ptr + 1;
      end
   end

   int rd_cnt = 0;
   int bad_re = 0;
   int acc_n = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int hold_err = 0;
   int re_cyc [0:63];
   int acc_cyc [0:63];
   logic [DW-1:0] acc_data [0:63];
   logic prev_v = 1'b0;
   logic prev_r = 1'b0;
   logic [DW-1:0] prev_d = '0;

   always @(negedge clk) begin
      if (!reset) begin
         if (Read_enable && rd_cnt < 64) begin
            re_cyc[rd_cnt] <= cyc;
            rd_cnt <= rd_cnt + 1;
            if (empty) bad_re <= bad_re + 1;
         end
         if (m_valid && m_ready && acc_n < 64) begin
            acc_data[acc_n] <= m_data;
            acc_cyc[acc_n] <= cyc;
            acc_n <= acc_n + 1;
         end
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (prev_v && !prev_r && (!m_valid || m_data !== prev_d))
            hold_err <= hold_err + 1;
         prev_v <= m_valid;
         prev_r <= m_ready;
         prev_d <= m_data;
      end else begin
         prev_v <= 1'b0;
      end
   end

   int checks = 0;
   int fails = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] w);
      mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic launch(input logic [LW-1:0] l);
      tick;
      start = 1'b1;
      burst_len = l;
      tick;
      start = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if (Read_enable !== 1'b0) begin
         fails++; $display("FAIL reset_re: got %0b expected 0", Read_enable);
      end
      checks++;
      if (m_valid !== 1'b0) begin
         fails++; $display("FAIL reset_valid: got %0b expected 0", m_valid);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL reset_flags: got busy=%0b done=%0b expected 0/0", busy, done);
      end
      checks++;
      if (word_count !== '0 || m_data !== '0) begin
         fails++; $display("FAIL reset_data: got wc=%0h data=%0h expected 0/0", word_count, m_data);
      end
      tick;
      reset = 1'b0;
   endtask

   task automatic test_basic;
      int b_rd, b_acc, b_done, n;
      b_rd = rd_cnt; b_acc = acc_n; b_done = done_cnt;
      for (int i = 1; i <= 4; i++) push(DW'(i));
      launch(4);
      n = 0;
      while (done_cnt == b_done && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (done_cnt == b_done) begin
         fails++; $display("FAIL basic_timeout: got no done expected done within 40 cycles");
      end
      tick;
      @(negedge clk);
      checks++;
      if (rd_cnt - b_rd !== 4) begin
         fails++; $display("FAIL basic_reads: got %0d expected 4", rd_cnt - b_rd);
      end
      checks++;
      if (re_cyc[b_rd+3] - re_cyc[b_rd] !== 3) begin
         fails++; $display("FAIL basic_re_consec: got span %0d expected 3", re_cyc[b_rd+3] - re_cyc[b_rd]);
      end
      checks++;
      if (acc_n - b_acc !== 4) begin
         fails++; $display("FAIL basic_count: got %0d expected 4", acc_n - b_acc);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (acc_data[b_acc+k] !== DW'(k + 1)) begin
            fails++; $display("FAIL basic_data%0d: got %0h expected %0h", k, acc_data[b_acc+k], k + 1);
         end
      end
      checks++;
      if (acc_cyc[b_acc+3] - acc_cyc[b_acc] !== 3) begin
         fails++; $display("FAIL basic_rate: got span %0d expected 3", acc_cyc[b_acc+3] - acc_cyc[b_acc]);
      end
      checks++;
      if (done_cyc !== acc_cyc[b_acc+3] + 1) begin
         fails++; $display("FAIL basic_done_time: got %0d expected %0d", done_cyc, acc_cyc[b_acc+3] + 1);
      end
      checks++;
      if (done_cnt - b_done !== 1) begin
         fails++; $display("FAIL basic_done_once: got %0d expected 1", done_cnt - b_done);
      end
      checks++;
      if (word_count !== LW'(4) || busy !== 1'b0) begin
         fails++; $display("FAIL basic_wc: got wc=%0d busy=%0b expected 4/0", word_count, busy);
      end
   endtask

   task automatic test_backpressure;
      int b_rd, b_acc, b_done, b_hold, n;
      b_rd = rd_cnt; b_acc = acc_n; b_done = done_cnt; b_hold = hold_err;
      push(32'hA1); push(32'hA2); push(32'hA3);
      m_ready = 1'b0;
      launch(3);
      repeat (10) tick;
      @(negedge clk);
      checks++;
      if (rd_cnt - b_rd > 2) begin
         fails++; $display("FAIL bp_reads: got %0d expected at most 2", rd_cnt - b_rd);
      end
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'hA1) begin
         fails++; $display("FAIL bp_hold: got valid=%0b data=%0h expected 1/a1", m_valid, m_data);
      end
      tick;
      m_ready = 1'b1;
      n = 0;
      while (done_cnt == b_done && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (done_cnt == b_done) begin
         fails++; $display("FAIL bp_timeout: got no done expected done within 40 cycles");
      end
      tick;
      @(negedge clk);
      checks++;
      if (acc_n - b_acc !== 3) begin
         fails++; $display("FAIL bp_count: got %0d expected 3", acc_n - b_acc);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (acc_data[b_acc+k] !== 32'hA1 + DW'(k)) begin
            fails++; $display("FAIL bp_data%0d: got %0h expected %0h", k, acc_data[b_acc+k], 32'hA1 + k);
         end
      end
      checks++;
      if (done_cnt - b_done !== 1 || word_count !== LW'(3)) begin
         fails++; $display("FAIL bp_done: got done=%0d wc=%0d expected 1/3", done_cnt - b_done, word_count);
      end
      checks++;
      if (hold_err != b_hold) begin
         fails++; $display("FAIL bp_stable: got %0d changes expected 0", hold_err - b_hold);
      end
   endtask

   task automatic test_empty_stall;
      int b_rd, b_acc, b_done, n;
      b_rd = rd_cnt; b_acc = acc_n; b_done = done_cnt;
      push(32'hB1); push(32'hB2);
      launch(5);
      repeat (6) tick;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL stall_busy: got %0b expected 1", busy);
      end
      checks++;
      if (rd_cnt - b_rd !== 2 || m_valid !== 1'b0) begin
         fails++; $display("FAIL stall_drain: got reads=%0d valid=%0b expected 2/0", rd_cnt - b_rd, m_valid);
      end
      tick;
      push(32'hB3); push(32'hB4); push(32'hB5);
      n = 0;
      while (done_cnt == b_done && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (done_cnt == b_done) begin
         fails++; $display("FAIL stall_timeout: got no done expected done within 40 cycles");
      end
      tick;
      @(negedge clk);
      checks++;
      if (acc_n - b_acc !== 5) begin
         fails++; $display("FAIL stall_count: got %0d expected 5", acc_n - b_acc);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (acc_data[b_acc+k] !== 32'hB1 + DW'(k)) begin
            fails++; $display("FAIL stall_data%0d: got %0h expected %0h", k, acc_data[b_acc+k], 32'hB1 + k);
         end
      end
      checks++;
      if (done_cnt - b_done !== 1 || word_count !== LW'(5)) begin
         fails++; $display("FAIL stall_done: got done=%0d wc=%0d expected 1/5", done_cnt - b_done, word_count);
      end
      checks++;
      if (bad_re !== 0) begin
         fails++; $display("FAIL stall_re_empty: got %0d expected 0", bad_re);
      end
   endtask

   task automatic test_zero_len;
      int b_rd, b_done;
      b_rd = rd_cnt; b_done = done_cnt;
      launch(0);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL zero_done: got done=%0b busy=%0b expected 1/0", done, busy);
      end
      checks++;
      if (word_count !== '0) begin
         fails++; $display("FAIL zero_wc: got %0d expected 0", word_count);
      end
      tick;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL zero_after: got done=%0b busy=%0b expected 0/0", done, busy);
      end
      checks++;
      if (rd_cnt - b_rd !== 0 || done_cnt - b_done !== 1) begin
         fails++; $display("FAIL zero_reads: got reads=%0d dones=%0d expected 0/1", rd_cnt - b_rd, done_cnt - b_done);
      end
   endtask

   task automatic test_back_to_back;
      int b_acc, b_done, n;
      b_acc = acc_n; b_done = done_cnt;
      for (int i = 0; i < 4; i++) push(32'hC1 + DW'(i));
      m_ready = 1'b0;
      launch(4);
      start = 1'b1;
      burst_len = 2;
      tick;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || word_count !== '0) begin
         fails++; $display("FAIL b2b_ignore: got busy=%0b wc=%0d expected 1/0", busy, word_count);
      end
      repeat (3) tick;
      m_ready = 1'b1;
      n = 0;
      while (done_cnt == b_done && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (done_cnt == b_done) begin
         fails++; $display("FAIL b2b_timeout: got no done expected done within 40 cycles");
      end
      tick;
      @(negedge clk);
      checks++;
      if (acc_n - b_acc !== 4 || word_count !== LW'(4)) begin
         fails++; $display("FAIL b2b_count: got %0d wc=%0d expected 4/4", acc_n - b_acc, word_count);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (acc_data[b_acc+k] !== 32'hC1 + DW'(k)) begin
            fails++; $display("FAIL b2b_data%0d: got %0h expected %0h", k, acc_data[b_acc+k], 32'hC1 + k);
         end
      end
   endtask

   task automatic test_reset_mid;
      int b_rd, b_acc, b_done, n;
      for (int i = 0; i < 4; i++) push(32'hD1 + DW'(i));
      m_ready = 1'b0;
      launch(4);
      n = 0;
      while (!m_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (m_valid !== 1'b1) begin
         fails++; $display("FAIL rst_mid_valid: got %0b expected 1", m_valid);
      end
      tick;
      reset = 1'b1;
      #1;
      checks++;
      if (m_valid !== 1'b0 || Read_enable !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL rst_mid_ctl: got v=%0b re=%0b busy=%0b expected 0/0/0", m_valid, Read_enable, busy);
      end
      checks++;
      if (done !== 1'b0 || word_count !== '0 || m_data !== '0) begin
         fails++; $display("FAIL rst_mid_data: got done=%0b wc=%0d data=%0h expected 0/0/0", done, word_count, m_data);
      end
      tick;
      reset = 1'b0;
      m_ready = 1'b1;
      b_rd = rd_cnt;
      repeat (3) tick;
      @(negedge clk);
      checks++;
      if (rd_cnt - b_rd !== 0 || m_valid !== 1'b0) begin
         fails++; $display("FAIL rst_mid_quiet: got reads=%0d valid=%0b expected 0/0", rd_cnt - b_rd, m_valid);
      end
      b_acc = acc_n; b_done = done_cnt;
      launch(2);
      n = 0;
      while (done_cnt == b_done && n < 40) begin @(negedge clk); n++; end
      tick;
      @(negedge clk);
      checks++;
      if (acc_n - b_acc !== 2) begin
         fails++; $display("FAIL rst_mid_count: got %0d expected 2", acc_n - b_acc);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (acc_data[b_acc+k] !== 32'hD3 + DW'(k)) begin
            fails++; $display("FAIL rst_mid_data%0d: got %0h expected %0h", k, acc_data[b_acc+k], 32'hD3 + k);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      burst_len = '0;
      m_ready = 1'b1;
      test_reset;
      test_basic;
      test_backpressure;
      test_empty_stall;
      test_zero_len;
      test_back_to_back;
      test_reset_mid;
      checks++;
      if (bad_re !== 0) begin
         fails++; $display("FAIL re_while_empty: got %0d expected 0", bad_re);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO words and stream data.
REQ-002 Parameter LEN_WIDTH, default 6, width of burst length and word counter; max burst 2**LEN_WIDTH-1.
REQ-003 The block SHALL use one clock, clk; reset is asynchronous and active-high, named reset.
REQ-004 clk  in  1  rising-edge clock shared with FIFO.
REQ-005 reset  in  1  async active-high reset.
REQ-006 empty  in  1  FIFO empty flag.
REQ-007 data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after a granted read.
REQ-008 Read_enable  out  1  FIFO read strobe.
REQ-009 start  in  1  burst request pulse.
REQ-010 burst_len  in  LEN_WIDTH  words to drain, sampled with start.
REQ-011 m_data  out  DATA_WIDTH  stream data.
REQ-012 m_valid  out  1  stream data valid.
REQ-013 m_ready  in  1  sink accepts when m_valid&&m_ready.
REQ-014 busy  out  1  burst in progress.
REQ-015 done  out  1  one-cycle pulse, burst complete.
REQ-016 word_count  out  LEN_WIDTH  words accepted by sink in current burst.

Function
REQ-017 FSM states: IDLE, RUN, FLUSH, DONE.
REQ-018 IDLE: start=1 with burst_len>0 -> RUN next cycle; latch len, clear issued count and word_count.
REQ-019 IDLE: start=1 with burst_len=0 -> DONE next cycle, no FIFO reads.
REQ-020 RUN: Read_enable = !empty && issued<len && (occ+inflight-pop)<2; occ = 2-entry output buffer occupancy, inflight = read issued last cycle, pop = m_valid&&m_ready.
REQ-021 Read_enable SHALL never be asserted while empty=1 or outside RUN.
REQ-022 Read issued in cycle N: data_out captured at end of N+1; m_valid asserted from cycle N+2 at earliest.
REQ-023 Sustained throughput 1 word/cycle when FIFO non-empty and m_ready=1.
REQ-024 Data SHALL leave in FIFO order; no loss, duplication or reordering.
REQ-025 m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-026 RUN -> FLUSH when issued reaches len; FLUSH -> DONE in the cycle after the last word is accepted.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 busy=1 in RUN and FLUSH, 0 in IDLE and DONE.
REQ-029 start while not IDLE SHALL be ignored.
REQ-030 word_count increments on each accept, saturates at len, held after done until next accepted start.
REQ-031 FIFO empty mid-burst: reads stall, buffered words still drain; resume when empty=0.

Reset
REQ-032 On reset assertion, immediately: state=IDLE, Read_enable=0, m_valid=0, busy=0, done=0, word_count=0, m_data=0, buffer and inflight cleared.
REQ-033 Reset mid-burst discards buffered/in-flight words; no output activity until a new start after reset release.

Verification
REQ-034 FIFO holds 0x1..0x4, start, burst_len=4, m_ready=1 -> Read_enable 4 consecutive cycles, m_data 0x1,0x2,0x3,0x4 on consecutive cycles, done one cycle after 0x4 accepted, word_count=4.
REQ-035 burst_len=3, m_ready=0 for 10 cycles then 1 -> at most 2 reads issued before backpressure release, m_data held at first word, all 3 delivered in order, done once.
REQ-036 FIFO empty after 2 of burst_len=5 words, refilled 6 cycles later -> no Read_enable while empty=1, busy stays 1, all 5 words delivered, done once.
REQ-037 start with burst_len=0 -> no Read_enable, done pulses the cycle after start, busy stays 0.
REQ-038 Reset asserted mid-burst with m_valid=1 -> all outputs 0 same cycle; second start during RUN ignored (word_count, len unchanged).
